// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave register that lets the PPC read a 32-bit word produced by fabric logic.
// The word is captured continuously or once per software arm, and a CTRL/STAT word is also readable.
module opb_register_simulink2ppc_snap #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0300,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_03FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [31:0]                 user_data_in,
  input  logic                        user_valid_in
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT_DESEL} state_t;

  state_t      state_q, state_d;
  logic [31:0] dbus_q, dbus_d;
  logic        rnw_q, rnw_d;
  logic        is_data_q, is_data_d;
  logic        is_ctrl_q, is_ctrl_d;
  logic [31:0] data_q, data_d;
  logic        armed_q, armed_d;
  logic        cont_q, cont_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;

  // Bus bit [31-i] is register bit i, so positional assignment does the reversal.
  logic [31:0] abus, wdata;
  logic [3:0]  be;
  assign abus  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;

  logic        hit;
  logic [5:0]  word_off;
  logic [31:0] stat_word, rd_word;
  logic        ack_cyc, rd_data_ack, wr_ctrl, capture;

  assign hit       = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign word_off  = abus[7:2] - C_BASEADDR[7:2];
  assign stat_word = {cnt_q, 13'b0, valid_q, cont_q, armed_q};
  assign rd_word   = (word_off == 6'd0) ? data_q :
                     (word_off == 6'd1) ? stat_word : 32'h0;

  assign ack_cyc     = (state_q == ST_ACK);
  assign rd_data_ack = ack_cyc && rnw_q && is_data_q;
  // Only byte lane 0 holds control bits; other lanes carry nothing writable.
  assign wr_ctrl     = ack_cyc && !rnw_q && is_ctrl_q && be[0];
  assign capture     = user_valid_in && (cont_q || armed_q);

  always_comb begin
    state_d   = state_q;
    dbus_d    = dbus_q;
    rnw_d     = rnw_q;
    is_data_d = is_data_q;
    is_ctrl_d = is_ctrl_q;
    data_d    = data_q;
    armed_d   = armed_q;
    cont_d    = cont_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (OPB_select && hit) begin
          state_d   = ST_ACK;
          rnw_d     = OPB_RNW;
          is_data_d = (word_off == 6'd0);
          is_ctrl_d = (word_off == 6'd1);
          dbus_d    = OPB_RNW ? rd_word : 32'h0;
        end
      end
      ST_ACK:        state_d = ST_WAIT_DESEL;
      ST_WAIT_DESEL: if (!OPB_select) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // Order sets priority: clears lose to a capture; arm and count-clear writes win.
    if (rd_data_ack)            valid_d = 1'b0;
    if (wr_ctrl && wdata[2])    valid_d = 1'b0;
    if (capture) begin
      data_d  = user_data_in;
      valid_d = 1'b1;
      armed_d = 1'b0;
      cnt_d   = cnt_q + 16'd1;
    end
    if (wr_ctrl) begin
      if (wdata[0]) armed_d = 1'b1;
      cont_d = wdata[1];
      if (wdata[3]) cnt_d = 16'd0;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q   <= ST_IDLE;
      dbus_q    <= 32'h0;
      rnw_q     <= 1'b0;
      is_data_q <= 1'b0;
      is_ctrl_q <= 1'b0;
      data_q    <= 32'h0;
      armed_q   <= 1'b0;
      cont_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      dbus_q    <= dbus_d;
      rnw_q     <= rnw_d;
      is_data_q <= is_data_d;
      is_ctrl_q <= is_ctrl_d;
      data_q    <= data_d;
      armed_q   <= armed_d;
      cont_q    <= cont_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  // Reset masks the ack immediately, even while the FSM still sits in ACK.
  assign Sl_xferAck = ack_cyc && !OPB_Rst;
  assign Sl_DBus    = Sl_xferAck ? dbus_q : 32'h0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, wdata[31:4], be[3:1], C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for opb_register_simulink2ppc_snap: vector table of OPB transactions and strobes,
// with read data predicted into a queue and compared whenever the slave acks.
module tb_opb_register_simulink2ppc_snap;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus, dbus, sl_dbus;
  logic [0:3]  be;
  logic        rnw, sel, seq;
  logic        ack, err, retry, tout;
  logic [31:0] udata;
  logic        uvalid;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
    .Sl_toutSup(tout), .user_data_in(udata), .user_valid_in(uvalid)
  );

  localparam logic [31:0] A_DATA = 32'h0100_0300;
  localparam logic [31:0] A_CTRL = 32'h0100_0304;
  localparam logic [31:0] A_OTHR = 32'h0100_0308;

  typedef struct {
    bit          kind;   // 0 = bus transaction, 1 = fabric strobe only
    logic [31:0] addr;
    bit          rnw;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          uv;     // strobe user_valid_in during the ack cycle
    logic [31:0] ud;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    int          id;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t tbl[$];
  int   ncomp = 0, nfail = 0, ack_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit kind, logic [31:0] addr, bit rd, logic [3:0] b,
                              logic [31:0] wd, bit uv, logic [31:0] ud, logic [31:0] exp);
    vec_t v;
    v.kind = kind; v.addr = addr; v.rnw = rd; v.be = b;
    v.wd = wd; v.uv = uv; v.ud = ud; v.exp = exp;
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack) begin
        ack_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.rd) chk($sformatf("rd_data[%0d]", mon_e.id), sl_dbus, mon_e.exp);
        end
      end else begin
        chk("dbus_zero_no_ack", sl_dbus, 32'h0);
      end
    end
  end

  task automatic bus_idle();
    sel = 1'b0; rnw = 1'b0; be = 4'h0; dbus = 32'h0; abus = 32'h0;
  endtask

  // Waits for the ack (bounded) then releases the bus; expects ack one cycle after select.
  task automatic wait_ack_release(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    chk({nm, "_ack_latency"}, n, 32'd1);
    if (!ack && sb_q.size() != 0) sb_q.delete(0);
    @(posedge clk); #1;
    uvalid = 1'b0;
    bus_idle();
    @(negedge clk);
    chk({nm, "_ack_width"}, {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    if (v.kind) begin
      uvalid = 1'b1; udata = v.ud;
      @(posedge clk); #1;
      uvalid = 1'b0;
    end else begin
      sb_q.push_back('{v.rnw, v.exp, id});
      abus = v.addr; rnw = v.rnw; be = v.be; dbus = v.rnw ? 32'h0 : v.wd; sel = 1'b1;
      @(negedge clk);
      chk($sformatf("ack_early[%0d]", id), {31'b0, ack}, 32'd0);
      @(posedge clk); #1;
      if (v.uv) begin uvalid = 1'b1; udata = v.ud; end
      wait_ack_release($sformatf("vec%0d", id));
    end
  endtask

  initial begin
    int a0;
    rst = 1'b1; seq = 1'b0; uvalid = 1'b0; udata = 32'h0;
    bus_idle();

    // R=read, W=write, S=strobe; expected values derived from the register map by hand.
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(mk(0, A_OTHR, 1, 4'hF, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(mk(0, A_DATA, 0, 4'hF, 32'hFFFF_FFFF, 0, 0, 0));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'h1, 0, 0, 0));            // arm
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0000_0001));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h1234_5678, 0));
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0001_0004));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0001_0000));
    tbl.push_back(mk(0, A_CTRL, 0, 4'b1110, 32'h3, 0, 0, 0));         // byte 0 disabled
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0001_0000));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'hA, 0, 0, 0));            // cont + clear count
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'hA, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'hB, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'hC, 0));
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0003_0006));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'h0000_000C));
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0003_0002));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'h6, 1, 32'h55, 0));       // valid clear vs capture
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0004_0006));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'hA, 1, 32'h66, 0));       // count clear vs capture
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0000_0006));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'h0, 0, 0, 0));            // one-shot mode
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0000_0004));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'h1, 1, 32'h77, 0));       // arm vs strobe
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0000_0005));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'h0000_0066));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h88, 0));
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0001_0004));
    tbl.push_back(mk(0, A_CTRL, 0, 4'hF, 32'h2, 0, 0, 0));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 1, 32'h99, 32'h0000_0088)); // read vs capture
    tbl.push_back(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0002_0006));
    tbl.push_back(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'h0000_0099));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_dbus", sl_dbus, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Select held for five cycles must produce exactly one ack.
    a0 = ack_cnt;
    sb_q.push_back('{1'b1, 32'h0002_0002, 100});
    abus = A_CTRL; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("long_select_ack_count", ack_cnt - a0, 32'd1);

    // Counter wrap: clear, then 65535 back-to-back captures, then one more.
    run_vec(mk(0, A_CTRL, 0, 4'hF, 32'hA, 0, 0, 0), 101);
    uvalid = 1'b1; udata = 32'hABCD_0000;
    repeat (65535) @(posedge clk);
    #1 uvalid = 1'b0;
    run_vec(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'hFFFF_0006), 102);
    run_vec(mk(1, 0, 0, 0, 0, 0, 32'h1234, 0), 103);
    run_vec(mk(0, A_CTRL, 1, 4'hF, 0, 0, 0, 32'h0000_0006), 104);

    // Reset during the ack cycle, with select still held when reset releases.
    abus = A_CTRL; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ack_no_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.push_back('{1'b1, 32'h0, 105});
    @(negedge clk);
    chk("post_rst_ack_early", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    wait_ack_release("post_rst");
    run_vec(mk(0, A_DATA, 1, 4'hF, 0, 0, 0, 32'h0000_0000), 106);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncomp, nfail);
    $finish;
  end

endmodule
